// File: rtl/mem_wb_stage_if.sv
// Upstream instruction, data-memory read and register-file write signals of the writeback stage.
interface mem_wb_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_aluResult;
  logic                  in_isLd;
  logic                  in_isWb;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  wb_ready;

  modport master (
    output in_valid, in_aluResult, in_isLd, in_isWb, in_rd, mem_rdata, wb_ready,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_aluResult, in_isLd, in_isWb, in_rd, mem_rdata, wb_ready,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Writeback stage: load-data alignment register, 2-entry result FIFO, register-file
// write handshake, youngest-first forwarding lookup and retired-instruction counter.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  mem_wb_stage_if.slave         bus,
  input  logic [REG_ADDR_W-1:0] fwd_rs,
  output logic                  fwd_hit,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [CNT_W-1:0]      retired_count
);

  logic                  s1_valid_r;
  logic [DATA_W-1:0]     s1_alu_r;
  logic                  s1_is_ld_r;
  logic                  s1_is_wb_r;
  logic [REG_ADDR_W-1:0] s1_rd_r;

  logic [DATA_W-1:0]     fifo_data_r [2];
  logic [REG_ADDR_W-1:0] fifo_rd_r   [2];
  logic [1:0]            fifo_wb_r;
  logic                  head_ptr_r;
  logic                  tail_ptr_r;
  logic [1:0]            count_r;
  logic [CNT_W-1:0]      retired_r;

  logic [DATA_W-1:0]     resolved_s;
  logic                  head_valid_s;
  logic                  pop_s;
  logic                  accept_s;
  logic                  in_ready_s;
  logic                  newest_ptr_s;
  logic [2:0]            occ_s;
  logic                  wr_en_s;
  logic [REG_ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0]     wr_data_s;
  logic                  fwd_hit_s;
  logic [DATA_W-1:0]     fwd_data_s;

  // Resolve S1, handshake decisions, write-port drive and forwarding lookup.
  always_comb begin
    resolved_s   = s1_is_ld_r ? bus.mem_rdata : s1_alu_r;
    head_valid_s = (count_r != 2'd0);
    pop_s        = head_valid_s && (!fifo_wb_r[head_ptr_r] || bus.wb_ready);
    occ_s        = {1'b0, count_r} + {2'b00, s1_valid_r} - {2'b00, pop_s};
    in_ready_s   = (occ_s < 3'd2);
    accept_s     = bus.in_valid && in_ready_s;
    newest_ptr_s = ~tail_ptr_r;

    wr_en_s   = 1'b0;
    wr_addr_s = {REG_ADDR_W{1'b0}};
    wr_data_s = {DATA_W{1'b0}};
    if (head_valid_s && fifo_wb_r[head_ptr_r]) begin
      wr_en_s   = 1'b1;
      wr_addr_s = fifo_rd_r[head_ptr_r];
      wr_data_s = fifo_data_r[head_ptr_r];
    end else begin
      wr_en_s   = 1'b0;
    end

    // With one entry queued the newest entry is the head, so the tail check only matters at two.
    fwd_hit_s  = 1'b0;
    fwd_data_s = {DATA_W{1'b0}};
    if (s1_valid_r && s1_is_wb_r && (s1_rd_r == fwd_rs)) begin
      fwd_hit_s  = 1'b1;
      fwd_data_s = resolved_s;
    end else if ((count_r == 2'd2) && fifo_wb_r[newest_ptr_s] && (fifo_rd_r[newest_ptr_s] == fwd_rs)) begin
      fwd_hit_s  = 1'b1;
      fwd_data_s = fifo_data_r[newest_ptr_s];
    end else if (head_valid_s && fifo_wb_r[head_ptr_r] && (fifo_rd_r[head_ptr_r] == fwd_rs)) begin
      fwd_hit_s  = 1'b1;
      fwd_data_s = fifo_data_r[head_ptr_r];
    end else begin
      fwd_hit_s  = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.wr_en     = wr_en_s;
  assign bus.wr_addr   = wr_addr_s;
  assign bus.wr_data   = wr_data_s;
  assign fwd_hit       = fwd_hit_s;
  assign fwd_data      = fwd_data_s;
  assign retired_count = retired_r;

  // S1 alignment register: holds an accepted instruction for the cycle its load data arrives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_r <= 1'b0;
      s1_alu_r   <= {DATA_W{1'b0}};
      s1_is_ld_r <= 1'b0;
      s1_is_wb_r <= 1'b0;
      s1_rd_r    <= {REG_ADDR_W{1'b0}};
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_alu_r   <= bus.in_aluResult;
      s1_is_ld_r <= bus.in_isLd;
      s1_is_wb_r <= bus.in_isWb;
      s1_rd_r    <= bus.in_rd;
    end else begin
      s1_valid_r <= 1'b0;
    end
  end

  // Result FIFO and retire counter; S1 always pushes, so the FIFO never back-pressures it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_data_r[0] <= {DATA_W{1'b0}};
      fifo_data_r[1] <= {DATA_W{1'b0}};
      fifo_rd_r[0]   <= {REG_ADDR_W{1'b0}};
      fifo_rd_r[1]   <= {REG_ADDR_W{1'b0}};
      fifo_wb_r      <= 2'b00;
      head_ptr_r     <= 1'b0;
      tail_ptr_r     <= 1'b0;
      count_r        <= 2'd0;
      retired_r      <= {CNT_W{1'b0}};
    end else begin
      if (s1_valid_r) begin
        fifo_data_r[tail_ptr_r] <= resolved_s;
        fifo_rd_r[tail_ptr_r]   <= s1_rd_r;
        fifo_wb_r[tail_ptr_r]   <= s1_is_wb_r;
        tail_ptr_r              <= ~tail_ptr_r;
      end
      if (pop_s) begin
        head_ptr_r <= ~head_ptr_r;
        retired_r  <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (s1_valid_r && !pop_s) begin
        count_r <= count_r + 2'd1;
      end else if (!s1_valid_r && pop_s) begin
        count_r <= count_r - 2'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised and directed bench for mem_wb_stage against a queue-based behavioural model.
module tb_mem_wb_stage;

  localparam int DW = 32;
  localparam int AW = 4;

  logic clk;
  logic rstn;
  logic [AW-1:0] fwd_rs;
  logic fwd_hit, fwd_hit4;
  logic [DW-1:0] fwd_data, fwd_data4;
  logic [31:0] retired_count;
  logic [3:0]  retired4;

  mem_wb_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();
  mem_wb_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus4 ();

  mem_wb_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(32)) u_dut (
    .clk(clk), .rstn(rstn), .bus(bus), .fwd_rs(fwd_rs),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .retired_count(retired_count)
  );

  // Narrow-counter copy sees identical stimulus; only its wrap behaviour is checked.
  mem_wb_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .bus(bus4), .fwd_rs(fwd_rs),
    .fwd_hit(fwd_hit4), .fwd_data(fwd_data4), .retired_count(retired4)
  );

  assign bus4.in_valid     = bus.in_valid;
  assign bus4.in_aluResult = bus.in_aluResult;
  assign bus4.in_isLd      = bus.in_isLd;
  assign bus4.in_isWb      = bus.in_isWb;
  assign bus4.in_rd        = bus.in_rd;
  assign bus4.mem_rdata    = bus.mem_rdata;
  assign bus4.wb_ready     = bus.wb_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] val;
    logic          wb;
    logic [AW-1:0] rd;
  } ent_t;

  ent_t          mq[$];
  bit            ms1_v;
  logic [DW-1:0] ms1_alu;
  bit            ms1_ld, ms1_wb;
  logic [AW-1:0] ms1_rd;
  int unsigned   mcount;

  logic [DW-1:0] e_res;
  bit            e_pop, e_ready, e_accept;
  logic [AW-1:0] got[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    ms1_v    = 1'b0;
    mcount   = 0;
    e_accept = 1'b0;
  endtask

  // Sample at the negedge: derive expectations from the model and compare every output.
  task automatic sample();
    bit            eh;
    logic [DW-1:0] ed;
    bit            ewe;
    @(negedge clk);
    e_res    = ms1_ld ? bus.mem_rdata : ms1_alu;
    e_pop    = (mq.size() > 0) && (!mq[0].wb || bus.wb_ready);
    e_ready  = (int'(mq.size()) + int'(ms1_v) - int'(e_pop)) < 2;
    e_accept = bus.in_valid && e_ready;
    ewe      = (mq.size() > 0) && mq[0].wb;
    eh = 1'b0;
    ed = '0;
    if (ms1_v && ms1_wb && ms1_rd == fwd_rs) begin
      eh = 1'b1;
      ed = e_res;
    end else begin
      for (int i = int'(mq.size()) - 1; i >= 0; i--) begin
        if (mq[i].wb && mq[i].rd == fwd_rs) begin
          eh = 1'b1;
          ed = mq[i].val;
          break;
        end
      end
    end
    chk("in_ready", 64'(bus.in_ready), 64'(e_ready));
    chk("wr_en", 64'(bus.wr_en), 64'(ewe));
    chk("wr_addr", 64'(bus.wr_addr), ewe ? 64'(mq[0].rd) : 64'd0);
    chk("wr_data", 64'(bus.wr_data), ewe ? 64'(mq[0].val) : 64'd0);
    chk("fwd_hit", 64'(fwd_hit), 64'(eh));
    chk("fwd_data", 64'(fwd_data), 64'(ed));
    chk("retired_count", 64'(retired_count), 64'(mcount));
    chk("retired_count_w4", 64'(retired4), 64'(mcount % 16));
    if (bus.wr_en && bus.wb_ready) got.push_back(bus.wr_addr);
  endtask

  task automatic finish_cycle();
    ent_t e;
    if (e_pop) begin
      void'(mq.pop_front());
      mcount++;
    end
    if (ms1_v) begin
      e.val = e_res;
      e.wb  = ms1_wb;
      e.rd  = ms1_rd;
      mq.push_back(e);
    end
    if (e_accept) begin
      ms1_v   = 1'b1;
      ms1_alu = bus.in_aluResult;
      ms1_ld  = bus.in_isLd;
      ms1_wb  = bus.in_isWb;
      ms1_rd  = bus.in_rd;
    end else begin
      ms1_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    finish_cycle();
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] alu, input bit ld, input bit wb, input logic [AW-1:0] rd);
    bus.in_valid     = v;
    bus.in_aluResult = alu;
    bus.in_isLd      = ld;
    bus.in_isWb      = wb;
    bus.in_rd        = rd;
  endtask

  // Reset lands between clock edges; outputs must clear before any further edge.
  task automatic do_reset();
    #2;
    rstn = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("rst_fwd_data", 64'(fwd_data), 64'd0);
    chk("rst_retired", 64'(retired_count), 64'd0);
    chk("rst_retired_w4", 64'(retired4), 64'd0);
    model_clear();
    repeat (3) @(posedge clk);
    #3;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int acc;
    rstn = 1'b0;
    fwd_rs = '0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    bus.mem_rdata = '0;
    bus.wb_ready  = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // ALU op: writes two cycles after acceptance, counted one cycle later.
    bus.wb_ready = 1'b1;
    fwd_rs = 4'd9;
    drive(1'b1, 32'h0000_1234, 1'b0, 1'b1, 4'd5);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    cyc();
    sample();
    chk("alu_wr_en", 64'(bus.wr_en), 64'd1);
    chk("alu_wr_addr", 64'(bus.wr_addr), 64'd5);
    chk("alu_wr_data", 64'(bus.wr_data), 64'h1234);
    finish_cycle();
    sample();
    chk("alu_retired", 64'(retired_count), 64'd1);
    finish_cycle();

    // Load alignment: memory data present only in the cycle after acceptance.
    do_reset();
    bus.wb_ready = 1'b0;
    drive(1'b1, 32'h40, 1'b1, 1'b1, 4'd3);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    bus.mem_rdata = 32'hDEAD_BEEF;
    cyc();
    bus.mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("ld_hold_wr_data", 64'(bus.wr_data), 64'hDEAD_BEEF);
      chk("ld_hold_wr_addr", 64'(bus.wr_addr), 64'd3);
      finish_cycle();
    end
    bus.wb_ready = 1'b1;
    sample();
    chk("ld_write_data", 64'(bus.wr_data), 64'hDEAD_BEEF);
    finish_cycle();
    sample();
    chk("ld_retired", 64'(retired_count), 64'd1);
    chk("ld_done_wr_en", 64'(bus.wr_en), 64'd0);
    finish_cycle();

    // Backpressure: only two accepted while the write port is blocked, then in-order drain.
    do_reset();
    got.delete();
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      bus.wb_ready = (c >= 5);
      if (idx < 4) drive(1'b1, 32'h11 * (idx + 1), 1'b0, 1'b1, 4'(idx + 1));
      else drive(1'b0, '0, 1'b0, 1'b0, '0);
      sample();
      if (c == 4) begin
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_accepted", 64'(idx), 64'd2);
      end
      finish_cycle();
      if (e_accept) idx++;
    end
    chk("bp_write_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("bp_write_order", 64'(got[i]), 64'(i + 1));

    // Store pops without a write; the following writer stalls at the head.
    do_reset();
    bus.wb_ready = 1'b0;
    drive(1'b1, 32'h55, 1'b0, 1'b0, 4'd6);
    cyc();
    drive(1'b1, 32'h77, 1'b0, 1'b1, 4'd7);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    sample();
    chk("st_no_wr_en", 64'(bus.wr_en), 64'd0);
    finish_cycle();
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("st_retired", 64'(retired_count), 64'd1);
      chk("st_stall_wr_en", 64'(bus.wr_en), 64'd1);
      chk("st_stall_addr", 64'(bus.wr_addr), 64'd7);
      finish_cycle();
    end

    // Forwarding priority: S1 beats the FIFO; a miss returns zero.
    do_reset();
    bus.wb_ready = 1'b0;
    fwd_rs = 4'd2;
    drive(1'b1, 32'hB, 1'b0, 1'b1, 4'd2);
    cyc();
    drive(1'b1, 32'hA, 1'b0, 1'b1, 4'd2);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    sample();
    chk("fwd_s1_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_s1_data", 64'(fwd_data), 64'hA);
    finish_cycle();
    fwd_rs = 4'd7;
    sample();
    chk("fwd_miss_hit", 64'(fwd_hit), 64'd0);
    chk("fwd_miss_data", 64'(fwd_data), 64'd0);
    finish_cycle();
    fwd_rs = 4'd2;
    sample();
    chk("fwd_tail_data", 64'(fwd_data), 64'hA);
    finish_cycle();

    // Sixteen retires wrap the 4-bit counter back to zero at full throughput.
    do_reset();
    bus.wb_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'($urandom_range(0, 1)), 4'(i));
      cyc();
      if (e_accept) acc++;
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    repeat (3) cyc();
    sample();
    chk("wrap_accepted", 64'(acc), 64'd16);
    chk("wrap_retired32", 64'(retired_count), 64'd16);
    chk("wrap_retired4", 64'(retired4), 64'd0);
    finish_cycle();

    // Randomised traffic with a mid-stream reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      if (!(bus.in_valid && !e_accept)) begin
        drive($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 4) != 0, 4'($urandom_range(0, 7)));
      end
      bus.wb_ready  = $urandom_range(0, 3) != 0;
      bus.mem_rdata = $urandom;
      fwd_rs        = 4'($urandom_range(0, 7));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Writeback stage directly downstream of the memory unit / data memory pair. It accepts one instruction per cycle from the execute/memory boundary and aligns each load with the data memory's registered read data, which arrives one cycle later. It buffers resolved results in a 2-entry FIFO, writes them to the register file under a ready handshake, and provides a forwarding lookup plus a retired-instruction counter.

Parameters:
DATA_W, 32, width of ALU result, load data and writeback data
REG_ADDR_W, 4, register-file address width
CNT_W, 32, retired-instruction counter width

Ports:
clk  input  1  clock; all state updates on posedge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  upstream holds a valid instruction
in_ready  output  1  stage can accept this cycle
in_aluResult  input  DATA_W  ALU result; also the load/store address
in_isLd  input  1  instruction is a load
in_isWb  input  1  instruction writes the register file
in_rd  input  REG_ADDR_W  destination register
mem_rdata  input  DATA_W  data memory read data, valid exactly one cycle after a load is accepted
wr_en  output  1  register-file write strobe
wr_addr  output  REG_ADDR_W  register-file write address
wr_data  output  DATA_W  register-file write data
wb_ready  input  1  register-file write port is free this cycle
fwd_rs  input  REG_ADDR_W  source register to look up
fwd_hit  output  1  an in-flight writer of fwd_rs exists
fwd_data  output  DATA_W  youngest in-flight value for fwd_rs
retired_count  output  CNT_W  number of instructions popped since reset

Behaviour:
- Accept: when in_valid and in_ready are both high at a posedge, the stage latches in_aluResult, in_isLd, in_isWb and in_rd into the S1 alignment register and sets s1_valid.
- Resolve: during a cycle with s1_valid high, the resolved value is mem_rdata if s1_isLd, otherwise s1_aluResult. It is resolved combinationally from that cycle's mem_rdata only.
- Enqueue: every cycle s1_valid is high, S1 (resolved value, isWb, rd) is pushed into the FIFO at the posedge. s1_valid then clears unless a new accept occurs in the same cycle. S1 never stalls, so mem_rdata is never sampled late.
- FIFO: 2 entries, in-order. head = oldest entry.
- pop = head_valid and (not head_isWb or wb_ready).
- An entry with isWb=0 (store or branch) pops in one cycle regardless of wb_ready and never asserts wr_en.
- Occupancy: occ = fifo_count + s1_valid. in_ready = (occ - pop) < 2, and is combinational.
- This rule guarantees the FIFO never overflows and sustains 1 instruction/cycle when wb_ready is held at 1.
- Write port: wr_en = head_valid and head_isWb. wr_addr and wr_data come from the head when wr_en is high, and are 0 otherwise. The write completes on a cycle where wr_en and wb_ready are both high.
- Latency: an instruction accepted at the cycle-N posedge appears at the FIFO head in cycle N+2. It writes in N+2 if wb_ready is high.
- Simultaneous push and pop on the FIFO: both take effect; the count is unchanged.
- Forwarding: fwd_hit=1 if any valid entry with isWb=1 has rd == fwd_rs.
  - Priority, youngest first: S1 (resolved value), then FIFO tail, then FIFO head.
  - fwd_data is the value of the highest-priority match, and 0 on a miss.
  - Forwarding is combinational.
- Counter: retired_count increments by 1 on every pop and wraps modulo 2^CNT_W.
- Reset: asserting rstn low, at any time including mid-stream, immediately clears:
  - s1_valid
  - FIFO pointers and count
  - retired_count
- After reset, outputs are: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, fwd_hit=0, fwd_data=0, retired_count=0.
  - In-flight instructions are discarded.
  - mem_rdata is ignored until the first load is accepted after rstn deasserts.
- Behaviour is undefined if in_* changes while in_valid is high and in_ready is low; upstream must hold them stable.

Test Plan:
1. Reset: pulse rstn low for 3 cycles, asynchronously to clk -> immediately in_ready=1, wr_en=0, retired_count=0, fwd_hit=0.
2. ALU op: accept aluResult=0x0000_1234, isWb=1, rd=5 at N, wb_ready=1 -> wr_en=1, wr_addr=5, wr_data=0x1234 in N+2; retired_count=1 in N+3.
3. Load alignment: accept isLd=1, rd=3, aluResult=0x40 at N; mem_rdata=0xDEADBEEF in N+1 only, then 0; wb_ready=0 for 5 cycles -> wr_data remains 0xDEADBEEF until wb_ready=1, then it is written to rd=3.
4. Backpressure: wb_ready=0, offer 4 back-to-back ALU ops (rd 1..4) -> exactly 2 accepted, then in_ready=0. Raise wb_ready -> all 4 written in order rd 1,2,3,4, one per cycle after the pipeline refills, with no loss or duplication.
5. Store/no-write: isWb=0 entry with wb_ready=0 -> pops without wr_en; retired_count increments; a following isWb=1 entry stalls at the head.
6. Forwarding priority: S1 holds rd=2 value 0xA, FIFO head holds rd=2 value 0xB, fwd_rs=2 -> fwd_hit=1, fwd_data=0xA. With fwd_rs=7 -> fwd_hit=0, fwd_data=0. Also run with CNT_W=4 and 16 retires -> retired_count wraps to 0.
